// File: rtl/data_mem_pkg.sv
// data_mem_pkg: MMIO offsets, STATUS bit layout and region decode type for data_mem_responder
package data_mem_pkg;
    localparam logic [3:0] LED_OFS    = 4'h0;
    localparam logic [3:0] TXPUSH_OFS = 4'h4;
    localparam logic [3:0] STATUS_OFS = 4'h8;
    localparam logic [3:0] CYCLES_OFS = 4'hC;
    localparam int ST_COUNT_W = 6;
    localparam int ST_EMPTY   = 6;
    localparam int ST_FULL    = 7;
    localparam int ST_OVF     = 8;
    typedef enum logic [2:0] {REG_RAM, REG_LED, REG_TXPUSH, REG_STATUS, REG_CYCLES, REG_NONE} region_t;
    function automatic logic [31:0] status_word(input logic ovf, input logic full, input logic empty,
                                                input logic [ST_COUNT_W-1:0] cnt);
        status_word = '0;
        status_word[ST_COUNT_W-1:0] = cnt;
        status_word[ST_EMPTY] = empty;
        status_word[ST_FULL] = full;
        status_word[ST_OVF] = ovf;
    endfunction
endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// tx_fifo: sync FIFO whose push is honoured when full only if a pop frees a slot the same edge
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic full,
    output logic empty,
    output logic drop,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop = push && !do_push;
    assign dout = empty ? '0 : mem[rp];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory port responder with word RAM, LED, TX FIFO, STATUS and cycle counter
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE = 32'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  Led,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady
);
    localparam int RW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] cycles;
    logic overflow, full, empty, drop;
    logic [CW-1:0] count;
    region_t region;
    always_comb begin
        region = REG_NONE;
        if (Addr < 32'(RAM_WORDS * 4))
            region = REG_RAM;
        else if (Addr[31:4] == MMIO_BASE[31:4])
            region = Addr[3:2] == LED_OFS[3:2]    ? REG_LED :
                     Addr[3:2] == TXPUSH_OFS[3:2] ? REG_TXPUSH :
                     Addr[3:2] == STATUS_OFS[3:2] ? REG_STATUS : REG_CYCLES;
    end
    tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(MemWrite && region == REG_TXPUSH),
        .pop(TxReady),
        .din(WriteData[7:0]),
        .dout(TxData),
        .full(full),
        .empty(empty),
        .drop(drop),
        .count(count)
    );
    assign TxValid = !empty;
    always_ff @(posedge clk) begin
        if (MemWrite && region == REG_RAM) ram[Addr[RW+1:2]] <= WriteData;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Led <= '0;
            cycles <= '0;
            overflow <= 1'b0;
        end else begin
            if (MemWrite && region == REG_LED) Led <= WriteData[7:0];
            cycles <= (MemWrite && region == REG_CYCLES) ? '0 : cycles + 32'd1;
            // a rejected push outranks a STATUS write on the same edge
            overflow <= drop || (overflow && !(MemWrite && region == REG_STATUS));
        end
    end
    always_comb begin
        ReadData = '0;
        case (region)
            REG_RAM:    ReadData = ram[Addr[RW+1:2]];
            REG_LED:    ReadData = {24'b0, Led};
            REG_STATUS: ReadData = status_word(overflow, full, empty, ST_COUNT_W'(count));
            REG_CYCLES: ReadData = cycles;
            default:    ReadData = '0;
        endcase
    end
endmodule
